// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter/rotator: stage k applies a 2^k step when shamt[k] is set.
// A single global advance moves every stage at once, so a stalled output freezes the pipe.
module shift_unit_pipe #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shamt,
    input  logic [2:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_carry,
    output logic          out_zero,
    output logic          out_err
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SLA = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    logic          valid_w [SW];
    logic [N-1:0]  data_w  [SW];
    logic          carry_w [SW];
    logic          err_w   [SW];
    logic [2:0]    op_w    [SW];
    logic [SW-1:0] shamt_w [SW];
    logic          advance;

    assign advance  = !valid_w[SW-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int SH = 1 << k;

        logic          s_valid;
        logic [N-1:0]  s_data;
        logic          s_carry;
        logic          s_err;
        logic [2:0]    s_op;
        logic [SW-1:0] s_shamt;

        logic          valid_q, valid_d;
        logic [N-1:0]  data_q, data_d;
        logic          carry_q, carry_d;
        logic          err_q, err_d;
        logic [2:0]    op_q, op_d;
        logic [SW-1:0] shamt_q, shamt_d;
        logic [N-1:0]  rot;

        if (k == 0) begin : g_head
            assign s_valid = in_valid;
            assign s_data  = in_data;
            assign s_carry = 1'b0;
            assign s_err   = in_op[2] & in_op[1];
            assign s_op    = in_op;
            assign s_shamt = in_shamt;
        end else begin : g_tail
            assign s_valid = valid_w[k-1];
            assign s_data  = data_w[k-1];
            assign s_carry = carry_w[k-1];
            assign s_err   = err_w[k-1];
            assign s_op    = op_w[k-1];
            assign s_shamt = shamt_w[k-1];
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            carry_d = carry_q;
            err_d   = err_q;
            op_d    = op_q;
            shamt_d = shamt_q;
            rot     = '0;
            if (advance) begin
                valid_d = s_valid;
                data_d  = s_data;
                carry_d = s_carry;
                err_d   = s_err;
                op_d    = s_op;
                shamt_d = s_shamt;
                // illegal ops pass through untouched with carry held at 0
                if (s_shamt[k] && !s_err) begin
                    case (s_op)
                        OP_SLL, OP_SLA: begin
                            data_d  = s_data << SH;
                            carry_d = s_data[N-SH];
                        end
                        OP_SRL: begin
                            data_d  = s_data >> SH;
                            carry_d = s_data[SH-1];
                        end
                        OP_SRA: begin
                            data_d  = $signed(s_data) >>> SH;
                            carry_d = s_data[SH-1];
                        end
                        OP_ROL: begin
                            rot     = (s_data << SH) | (s_data >> (N - SH));
                            data_d  = rot;
                            carry_d = rot[0];
                        end
                        OP_ROR: begin
                            rot     = (s_data >> SH) | (s_data << (N - SH));
                            data_d  = rot;
                            carry_d = rot[N-1];
                        end
                        default: ;
                    endcase
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                carry_q <= 1'b0;
                err_q   <= 1'b0;
                op_q    <= '0;
                shamt_q <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                carry_q <= carry_d;
                err_q   <= err_d;
                op_q    <= op_d;
                shamt_q <= shamt_d;
            end
        end

        assign valid_w[k] = valid_q;
        assign data_w[k]  = data_q;
        assign carry_w[k] = carry_q;
        assign err_w[k]   = err_q;
        assign op_w[k]    = op_q;
        assign shamt_w[k] = shamt_q;
    end

    assign out_valid = valid_w[SW-1];
    assign out_data  = data_w[SW-1];
    assign out_carry = carry_w[SW-1];
    assign out_err   = err_w[SW-1];
    assign out_zero  = (out_data == '0);

    logic unused_tail;
    assign unused_tail = ^{op_w[SW-1], shamt_w[SW-1]};

endmodule
